// File: rtl/adc_frame_capture.sv
`timescale 1ns/1ps
// adc_frame_capture
// Captures stereo I2S frames from an audio codec ADC into a single-entry
// holding register with a valid/ready handshake toward the consumer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | capture disabled; waits for enable
// ARM   | waits for a left-channel LRCK edge to align to a frame start
// SHIFT | shifting serial data into the current channel word
// WAIT  | word complete, ignoring surplus slot bits until the next LRCK edge
//
// The BCLK rise that carries an LRCK edge is the I2S delay slot of the new
// channel, but it also carries the LSB of the previous channel's word. So
// in SHIFT, the rise that delivers the last bit completes the word even if
// LRCK toggles on that same rise; that edge then starts the next channel
// directly. An edge on any earlier rise is a short word and aborts the frame.
module adc_frame_capture #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      enable,
    input  logic                      AUD_BCLK,
    input  logic                      AUD_ADCLRCK,
    input  logic                      AUD_ADCDAT,
    output logic [2*SAMPLE_WIDTH-1:0] ADCDATA,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic                      overrun,
    output logic                      frame_error
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0]  bclk_sync;
    logic [SYNC_STAGES-1:0]  lrck_sync;
    logic [SYNC_STAGES-1:0]  dat_sync;
    logic                    bclk_s;
    logic                    lrck_s;
    logic                    dat_s;
    logic                    bclk_prev;
    logic                    lrck_prev;
    logic                    bclk_rise;
    logic                    lrck_edge;
    logic                    left_edge;

    logic [CW-1:0]           bit_cnt;
    logic                    chan_right;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] word_next;
    logic [SAMPLE_WIDTH-1:0] left_word;
    logic                    left_valid;

    logic                    shift_en;
    logic                    word_done;
    logic                    chan_start;
    logic                    abort;
    logic                    frame_done;

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev;
    assign lrck_edge = bclk_rise & (lrck_s != lrck_prev);
    assign left_edge = bclk_rise & lrck_prev & ~lrck_s;

    // Word as it will look after shifting in the bit at this rise.
    assign word_next = SAMPLE_WIDTH'({shift_reg, dat_s});

    assign frame_done = word_done & chan_right & left_valid;

    // Resynchronize the codec-domain inputs into Clk.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
        end else begin
            bclk_sync[0] <= AUD_BCLK;
            lrck_sync[0] <= AUD_ADCLRCK;
            dat_sync[0]  <= AUD_ADCDAT;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                bclk_sync[i] <= bclk_sync[i-1];
                lrck_sync[i] <= lrck_sync[i-1];
                dat_sync[i]  <= dat_sync[i-1];
            end
        end
    end

    // Track BCLK level for rise detection and LRCK as seen at the last rise.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_prev <= bclk_s;
            if (bclk_rise) begin
                lrck_prev <= lrck_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and per-rise datapath controls.
    always_comb begin
        state_nxt  = state;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        chan_start = 1'b0;
        abort      = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                end
                ARM: begin
                    if (left_edge) begin
                        chan_start = 1'b1;
                        state_nxt  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bclk_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            word_done = 1'b1;
                            if (lrck_edge) begin
                                chan_start = 1'b1;
                                state_nxt  = SHIFT;
                            end else begin
                                state_nxt  = WAIT;
                            end
                        end else if (lrck_edge) begin
                            abort     = 1'b1;
                            state_nxt = ARM;
                        end
                    end
                end
                WAIT: begin
                    if (lrck_edge) begin
                        chan_start = 1'b1;
                        state_nxt  = SHIFT;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Bit counter, channel tag and serial shift register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bit_cnt    <= '0;
            chan_right <= 1'b0;
            shift_reg  <= '0;
        end else begin
            if (chan_start) begin
                bit_cnt    <= '0;
                chan_right <= lrck_s;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= word_next;
            end
        end
    end

    // Stored left word; only a left word from the current frame may pair
    // with a right word.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            left_word  <= '0;
            left_valid <= 1'b0;
        end else begin
            if (!enable || abort) begin
                left_valid <= 1'b0;
            end else if (word_done && !chan_right) begin
                left_word  <= word_next;
                left_valid <= 1'b1;
            end else if (word_done && chan_right) begin
                left_valid <= 1'b0;
            end else if (chan_start && !lrck_s) begin
                left_valid <= 1'b0;
            end
        end
    end

    // Holding register with consumer handshake and sticky status flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ADCDATA      <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            if (frame_done && (!sample_valid || sample_ready)) begin
                ADCDATA      <= {left_word, word_next};
                sample_valid <= 1'b1;
            end else begin
                if (frame_done) begin
                    overrun <= 1'b1;
                end
                if (sample_valid && sample_ready) begin
                    sample_valid <= 1'b0;
                end
            end
            if (abort) begin
                frame_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_capture.sv
`timescale 1ns/1ps
// Bench for adc_frame_capture: drives an I2S bit stream and compares the
// delivered frames and status flags with a frame-level reference model.
module tb_adc_frame_capture;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        enable;
    logic        AUD_BCLK;
    logic        AUD_ADCLRCK;
    logic        AUD_ADCDAT;
    logic [31:0] ADCDATA;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        frame_error;

    adc_frame_capture #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .enable       (enable),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_ADCLRCK  (AUD_ADCLRCK),
        .AUD_ADCDAT   (AUD_ADCDAT),
        .ADCDATA      (ADCDATA),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_error  (frame_error)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: what the consumer should see, frame by frame.
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit          exp_hold = 0;
    bit          exp_ovr  = 0;
    bit          exp_ferr = 0;
    logic [31:0] pend;
    bit          pend_ok  = 0;
    bit          cap_on   = 0;
    logic        prev_lsb = 1'b0;

    // Monitor state.
    logic sv_d     = 1'b0;
    int   run_len  = 0;
    int   max_run  = 0;
    int   sv_falls = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // A complete left/right pair reached the capture block.
    task automatic model_complete(input logic [31:0] data);
        if (!exp_hold) begin
            exp_q.push_back(data);
            if (!sample_ready) exp_hold = 1;
        end else begin
            exp_ovr = 1;
        end
    endtask

    task automatic model_reset();
        exp_hold = 0;
        exp_ovr  = 0;
        exp_ferr = 0;
        pend_ok  = 0;
    endtask

    task automatic set_enable(input logic v);
        @(negedge Clk);
        enable = v;
        cap_on = v;
        if (!v) pend_ok = 0;
        repeat (3) @(negedge Clk);
    endtask

    // One BCLK period: LRCK/DAT change while BCLK is low, sampled at the rise.
    task automatic bclk_period(input logic lr, input logic d);
        @(negedge Clk);
        AUD_ADCLRCK = lr;
        AUD_ADCDAT  = d;
        AUD_BCLK    = 1'b0;
        repeat (4) @(negedge Clk);
        AUD_BCLK    = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    // Periods [first,last) of a 32-BCLK I2S frame. Period 0 carries the LSB
    // of the previous right word; period 16 carries the LSB of this left word.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int first, input int last);
        logic lr;
        logic d;
        if (first == 0) begin
            if (pend_ok) model_complete(pend);
            pend_ok = 0;
        end
        for (int p = first; p < last; p++) begin
            if (p < 16) begin
                lr = 1'b0;
                d  = (p == 0) ? prev_lsb : l[16-p];
            end else begin
                lr = 1'b1;
                d  = (p == 16) ? l[0] : r[32-p];
            end
            bclk_period(lr, d);
        end
        if (last == 32) prev_lsb = r[0];
        if (first == 0 && last == 32 && cap_on) begin
            pend    = {l, r};
            pend_ok = 1;
        end
    endtask

    task automatic compare_section(input string tag);
        int n;
        repeat (20) @(negedge Clk);
        check_val({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_frame%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        check_val({tag, "_overrun"}, 64'(overrun), 64'(exp_ovr));
        check_val({tag, "_frame_error"}, 64'(frame_error), 64'(exp_ferr));
        got_q.delete();
        exp_q.delete();
    endtask

    // Record each new frame presented, and sample_valid run lengths.
    always @(negedge Clk) begin
        if (sample_valid && !sv_d) got_q.push_back(ADCDATA);
        if (!sample_valid && sv_d) sv_falls++;
        if (sample_valid) run_len++;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        sv_d = sample_valid;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] hold_val;
        logic [15:0] gl[6];
        logic [15:0] gr[6];

        Reset        = 1'b1;
        enable       = 1'b0;
        AUD_BCLK     = 1'b1;
        AUD_ADCLRCK  = 1'b1;
        AUD_ADCDAT   = 1'b0;
        sample_ready = 1'b1;
        repeat (5) @(negedge Clk);
        check_val("rst_adcdata", 64'(ADCDATA), 64'h0);
        check_val("rst_valid", 64'(sample_valid), 64'h0);
        check_val("rst_overrun", 64'(overrun), 64'h0);
        check_val("rst_frame_error", 64'(frame_error), 64'h0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);

        // Stream joins mid right channel; fixed then random frames, ready held.
        set_enable(1'b1);
        for (int i = 0; i < 5; i++) bclk_period(1'b1, 1'($urandom));
        max_run = 0;
        for (int i = 0; i < 3; i++) send_frame(16'hA5C3, 16'h1234, 0, 32);
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            send_frame(a, b, 0, 32);
        end
        send_frame(16'h0, 16'h0, 0, 32);
        compare_section("stream");
        check_val("stream_valid_pulse", 64'(max_run), 64'd1);
        set_enable(1'b0);

        // Consumer stalled over two frames: first is held, second overruns.
        sample_ready = 1'b0;
        sv_falls = 0;
        set_enable(1'b1);
        send_frame(16'h1111, 16'h2222, 0, 32);
        send_frame(16'h3333, 16'h4444, 0, 32);
        check_val("stall_overrun_first", 64'(overrun), 64'(exp_ovr));
        check_val("stall_valid_first", 64'(sample_valid), 64'h1);
        send_frame(16'h0, 16'h0, 0, 32);
        repeat (10) @(negedge Clk);
        check_val("stall_adcdata", 64'(ADCDATA), 64'h11112222);
        check_val("stall_valid_held", 64'(sample_valid), 64'h1);
        check_val("stall_no_drop", 64'(sv_falls), 64'd0);
        sample_ready = 1'b1;
        @(negedge Clk);
        sample_ready = 1'b0;
        exp_hold = 0;
        check_val("accept_valid", 64'(sample_valid), 64'h0);
        check_val("accept_adcdata", 64'(ADCDATA), 64'h11112222);
        compare_section("stall");
        set_enable(1'b0);

        // LRCK toggles after 9 left bits, then a clean frame.
        sample_ready = 1'b1;
        set_enable(1'b1);
        bclk_period(1'b0, prev_lsb);
        for (int i = 0; i < 9; i++) bclk_period(1'b0, 1'($urandom));
        for (int i = 0; i < 16; i++) bclk_period(1'b1, 1'b0);
        prev_lsb = 1'b0;
        exp_ferr = 1;
        send_frame(16'h0F0F, 16'hF0F0, 0, 32);
        send_frame(16'h0, 16'h0, 0, 32);
        compare_section("short_word");
        set_enable(1'b0);

        // Reset during bit 7 of a right word, then resume.
        set_enable(1'b1);
        a = 16'($urandom);
        b = 16'($urandom);
        send_frame(a, b, 0, 32);
        send_frame(16'h5A5A, 16'hC3C3, 0, 26);
        hold_val = {a, b};
        check_val("pre_reset_adcdata", 64'(ADCDATA), 64'(hold_val));
        compare_section("pre_reset");
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check_val("mid_reset_adcdata", 64'(ADCDATA), 64'h0);
        check_val("mid_reset_valid", 64'(sample_valid), 64'h0);
        check_val("mid_reset_overrun", 64'(overrun), 64'h0);
        check_val("mid_reset_frame_error", 64'(frame_error), 64'h0);
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        send_frame(16'h5A5A, 16'hC3C3, 26, 32);
        for (int i = 0; i < 2; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            send_frame(a, b, 0, 32);
        end
        send_frame(16'h0, 16'h0, 0, 32);
        compare_section("post_reset");
        set_enable(1'b0);

        // Enable dropped mid-frame while a frame is held.
        for (int i = 0; i < 6; i++) begin
            gl[i] = 16'($urandom);
            gr[i] = 16'($urandom);
        end
        sample_ready = 1'b0;
        sv_falls = 0;
        set_enable(1'b1);
        send_frame(gl[0], gr[0], 0, 32);
        send_frame(gl[1], gr[1], 0, 10);
        set_enable(1'b0);
        send_frame(gl[1], gr[1], 10, 32);
        send_frame(gl[2], gr[2], 0, 32);
        send_frame(gl[3], gr[3], 0, 20);
        send_frame(gl[3], gr[3], 20, 32);
        hold_val = {gl[0], gr[0]};
        check_val("disabled_adcdata", 64'(ADCDATA), 64'(hold_val));
        check_val("disabled_valid", 64'(sample_valid), 64'h1);
        check_val("disabled_no_drop", 64'(sv_falls), 64'd0);
        check_val("disabled_overrun", 64'(overrun), 64'h0);
        sample_ready = 1'b1;
        exp_hold = 0;
        repeat (3) @(negedge Clk);
        check_val("disabled_consumed", 64'(sample_valid), 64'h0);
        set_enable(1'b1);
        send_frame(gl[4], gr[4], 0, 32);
        send_frame(gl[5], gr[5], 0, 32);
        send_frame(16'h0, 16'h0, 0, 32);
        compare_section("reenable");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
